// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit add/subtract unit: one full-adder cell per cycle, LSB first,
// with the carry held in a flop between bits and valid/ready handshakes on both sides.
module serial_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             c_q, c_d, cout_q, cout_d, ovf_q, ovf_d;
    logic             s_bit, co_bit, last_bit;

    always_comb begin
        s_bit    = a_q[0] ^ b_q[0] ^ c_q;
        co_bit   = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));
        last_bit = (cnt_q == LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last_bit)  state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Subtraction is a + ~b + 1, so B is inverted and the carry forced on load.
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        sum_d  = sum_q;
        cnt_d  = cnt_q;
        c_d    = c_q;
        cout_d = cout_q;
        ovf_d  = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d   = a;
                    b_d   = sub ? ~b : b;
                    c_d   = sub ? 1'b1 : cin;
                    cnt_d = '0;
                end
            end
            RUN: begin
                sum_d = {s_bit, sum_q[WIDTH-1:1]};
                a_d   = {1'b0, a_q[WIDTH-1:1]};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                c_d   = co_bit;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    cout_d = co_bit;
                    ovf_d  = c_q ^ co_bit;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q  <= '0;
            cnt_q  <= '0;
            c_q    <= 1'b0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cnt_q  <= cnt_d;
            c_q    <= c_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
        end
    end

    // Operand shifters carry no meaning outside RUN, so they need no reset.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        sum       = sum_q;
        cout      = cout_q;
        overflow  = ovf_q;
    end
endmodule

// File: tb/tb_serial_adder.sv
// Randomized and directed bench for serial_adder against an arithmetic reference model.
module tb_serial_adder;
    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] exp_sum;
    logic             exp_cout;
    logic             exp_ovf;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic for the result, signed range test for overflow.
    task automatic model(input logic [31:0] ta, input logic [31:0] tb_, input logic tc, input logic ts);
        logic [32:0] full;
        longint      sa, sb, r;
        full = {1'b0, ta} + {1'b0, (ts ? ~tb_ : tb_)} + 33'(ts ? 1'b1 : tc);
        sa = longint'($signed(ta));
        sb = longint'($signed(tb_));
        r  = ts ? (sa - sb) : (sa + sb + longint'(tc));
        exp_sum  = full[31:0];
        exp_cout = full[32];
        exp_ovf  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [31:0] ta, input logic [31:0] tb_, input logic tc, input logic ts);
        check("in_ready_before_accept", in_ready, 1);
        model(ta, tb_, tc, ts);
        a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!out_valid && n < WIDTH + 8) begin
            step();
            n++;
        end
        check("latency", 64'(n), 64'(WIDTH));
        check("sum", sum, exp_sum);
        check("cout", cout, exp_cout);
        check("overflow", overflow, exp_ovf);
    endtask

    task automatic finish_op(input int stall);
        out_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            step();
            check("stall_sum", sum, exp_sum);
            check("stall_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("idle_after_handshake", {in_ready, out_valid}, 2'b10);
    endtask

    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_, input logic tc, input logic ts, input int stall);
        start_op(ta, tb_, tc, ts);
        wait_done();
        finish_op(stall);
    endtask

    initial begin
        logic [31:0] hold_sum;
        logic        hold_cout, hold_ovf;
        int          seen;

        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", overflow, 0);

        run_op(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 0);
        run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 0);
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
        run_op(32'd5, 32'd7, 1'b1, 1'b1, 0);
        run_op(32'd7, 32'd5, 1'b0, 1'b1, 0);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 0);
        run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 0);

        // Backpressure with new operands waiting on the input side.
        start_op(32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b0);
        wait_done();
        hold_sum = exp_sum; hold_cout = exp_cout; hold_ovf = exp_ovf;
        a = 32'h0000_1000; b = 32'h0000_0234; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_sum", sum, hold_sum);
            check("bp_cout", cout, hold_cout);
            check("bp_ovf", overflow, hold_ovf);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_idle_after_hs", {in_ready, out_valid}, 2'b10);
        start_op(32'h0000_1000, 32'h0000_0234, 1'b0, 1'b0);
        wait_done();
        finish_op(0);

        // Reset pulse on the 10th RUN cycle aborts the operation.
        start_op(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0);
        repeat (9) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_sum", sum, 0);
        seen = 0;
        for (int i = 0; i < WIDTH + 4; i++) begin
            if (out_valid) seen++;
            step();
        end
        check("midrst_no_valid", 64'(seen), 0);
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 0);
        check("midrst_next_sum", exp_sum, 32'h2345_6789);

        for (int k = 0; k < 1000; k++) begin
            run_op($urandom, $urandom, 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit add/subtract unit that processes operands LSB-first, one full-adder cell per cycle, with the carry held in a flip-flop between bits. It sits between the operand source and the result consumer in the datapath. It trades latency for area against the ripple-carry adders built from the same one-bit cell. Valid/ready handshakes on both sides let it be stalled by either neighbour.

## Interface
- WIDTH, 32, operand/result width in bits; legal range 2..64.
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a/b/cin/sub are valid this cycle.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in for add; ignored when sub=1.
- sub  input  1  1 = compute a - b (b inverted, initial carry forced to 1).
- out_valid  output  1  sum/cout/overflow valid; high only in DONE.
- out_ready  input  1  consumer accepts result this cycle.
- sum  output  WIDTH  result, a + b + cin or a - b, modulo 2^WIDTH.
- cout  output  1  carry out of MSB; for sub, 1 = no borrow.
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE, RUN, DONE. in_ready = (state==IDLE); out_valid = (state==DONE).
- IDLE: on in_valid && in_ready, load a into A shift register, b (or ~b if sub) into B shift register, carry flop = sub ? 1 : cin, bit counter = 0, go RUN. Operands are sampled only on this accept edge.
- RUN: each cycle the cell computes s = A0 ^ B0 ^ c and co = (A0 & B0) | (c & (A0 ^ B0)).
  - s shifts into the sum register at the MSB end, so bit i lands at sum[i] after WIDTH shifts.
  - A and B shift right by one; carry flop <= co; counter increments.
  - On the bit with counter == WIDTH-1, capture the carry-in of that bit as c_msb and co as cout, then go DONE.
- DONE: sum, cout and overflow = c_msb ^ cout are held stable until out_valid && out_ready, then go IDLE. No accept occurs in the same cycle as the result handshake; in_ready rises the following cycle.
- in_valid is ignored outside IDLE. Input changes during RUN/DONE have no effect.
- Counter width is $clog2(WIDTH). No wrap occurs because the RUN exit is forced at WIDTH-1.

## Timing
- Reset (any state, including mid-RUN): state = IDLE, sum = 0, cout = 0, overflow = 0, carry flop = 0, counter = 0. After reset, in_ready = 1 and out_valid = 0.
- Reset mid-operation aborts the operation; no out_valid is produced for it.
- Latency: accept on edge E0; RUN edges E1..EWIDTH; out_valid high in the cycle after EWIDTH, i.e. WIDTH cycles after the accept edge.
- Throughput: one operation per WIDTH+2 cycles with out_ready held high (accept, WIDTH RUN cycles, DONE handshake cycle, IDLE cycle).
- out_ready low in DONE stalls indefinitely; all outputs stay constant during the stall.
- All outputs are registered or decoded from the state register. There is no combinational path from inputs to outputs.

## Test plan
- Add (WIDTH=32): a=0x00000005, b=0x00000003, cin=0, sub=0 -> out_valid exactly 32 cycles after accept; sum=0x00000008, cout=0, overflow=0.
- Carry and wrap: a=0xFFFFFFFF, b=0x00000000, cin=1 -> sum=0x00000000, cout=1, overflow=0. Also a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, cout=0, overflow=1.
- Subtract: a=5, b=7, sub=1, cin=1 -> sum=0xFFFFFFFE, cout=0, overflow=0. Then a=7, b=5, sub=1, cin=0 -> sum=0x00000002, cout=1, overflow=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while in_valid=1 with new operands -> sum/cout/overflow unchanged, in_ready=0, no new accept. Raise out_ready -> handshake, IDLE next cycle, then the new operands are accepted.
- Reset mid-RUN: assert reset for 1 cycle on the 10th RUN cycle -> out_valid never rises for that operation; in_ready=1 the cycle after reset; the next add 0x12345678 + 0x11111111 gives 0x23456789, cout=0.
- Back-to-back random: 1000 random a/b/cin/sub with random out_ready -> each result matches the reference model {cout,sum} = a + (sub ? ~b : b) + (sub ? 1 : cin), and overflow matches signed overflow.
